gpp_core_param: RTL
===================

Name: gpp_core_param

Overview:
Parametrised multi-cycle MIPS-subset processor core, the next generation of the team's single-channel GPP.
- Fetches 32-bit-format instructions from an external instruction memory over a req/ack handshake.
- Executes them against an internal register file and flags completion or error.
- Generalised in data width, address width, register count and program length.
- Adds Start, memory wait states, branches, logic ops, a HALT opcode and error reporting.

Parameters:
DW, 32, datapath and register width (>=16)
AW, 16, instruction address width
RA_W, 5, register address width; 2**RA_W registers, r0 hardwired to 0
PROG_LEN, 256, maximum instructions fetched before forced stop (1..2**AW)

Ports:
Clk  in  1  clock, rising edge
Rst  in  1  reset, synchronous, active-high
Start  in  1  pulse; begins execution at address 0 when idle
Addr  out  AW  instruction fetch address
RData  in  32  instruction word, valid when MemAck=1
MemReq  out  1  fetch request
MemAck  in  1  memory acknowledge; RData sampled in that cycle
Busy  out  1  high from Start acceptance until Done/Err
Done  out  1  sticky, high after normal termination
Err  out  1  sticky, high after abnormal termination
PC_out  out  AW  current PC (debug)

Behaviour:
- Reset (Rst=1 at posedge):
  - State=IDLE, PC=0, IR=0.
  - All registers cleared.
  - Addr=0, MemReq=0, Busy=0, Done=0, Err=0.
  - Reset mid-fetch drops MemReq the next cycle; a late MemAck is ignored.
- States: IDLE -> FETCH -> DECODE -> EXEC -> FETCH..., plus terminal DONE and ERROR.
- IDLE:
  - Start=1 clears Done/Err and sets PC=0, Busy=1; go to FETCH.
  - Start while Busy is ignored.
- FETCH:
  - If the fetched-instruction count equals PROG_LEN, go to DONE.
  - Otherwise drive Addr=PC, MemReq=1 and hold both stable until MemAck=1.
  - On ack, latch IR=RData and set MemReq=0 next cycle; go to DECODE.
  - Zero-wait memory gives a minimum instruction latency of 3 cycles (FETCH, DECODE, EXEC).
- DECODE: split IR into op[31:26], rs[25:21], rt[20:16], rd[15:11], sh[10:6], fn[5:0], imm[15:0].
  - Register fields are truncated to RA_W bits.
  - Register reads are combinational.
- EXEC: one cycle; writeback at the end of EXEC; PC=PC+1 unless a branch is taken.
- R-type instructions (op=0), each writing regs[rd]:
  - fn0 SLL: regs[rt]<<sh
  - fn2 SRL: logical shift, regs[rt]>>sh
  - fn24 MUL: low DW bits of regs[rs]*regs[rt]
  - fn26 DIV: unsigned regs[rs]/regs[rt]
  - fn32 ADD, fn34 SUB: modulo 2**DW, no overflow trap
  - fn36 AND, fn37 OR
  - Any other fn: go to ERROR.
- op8 ADDI: regs[rt]=regs[rs]+sign-extended imm.
- op4 BEQ / op5 BNE: if the condition holds, PC=PC+1+sign-extended imm, wrapping modulo 2**AW.
- op63 HALT: go to DONE; PC not incremented.
- Any other op: go to ERROR.
- Writes to r0 are discarded; r0 always reads 0.
- DONE: Done=1, Busy=0, return to IDLE. Done stays high until the next accepted Start or Rst.
- ERROR: Err=1, Busy=0, return to IDLE. PC_out holds the faulting instruction address.
- PC wraps from 2**AW-1 to 0. The PROG_LEN limit still bounds runaway loops.

Optional Feature:
Macro GPP_DIV_EN.
- Defined:
  - DIV (fn26) is implemented.
  - Divide by zero sets regs[rd] to all ones, sets Err=1 and terminates via ERROR.
- Undefined:
  - No divider is synthesised.
  - fn26 is treated as an illegal function and goes to ERROR without any register write.

Test Plan:
- Program: ADDI r1,r0,5; ADDI r2,r0,3; ADD r3,r1,r2; SUB r4,r1,r2; HALT; zero-wait memory -> r3=8, r4=2, Done=1 after 5 instructions, Busy falls at the same time, Err=0.
- Program: ADDI r1,r0,3; ADDI r1,r1,-1; BNE r1,r0,-2; HALT -> loop body runs 3 times, r1=0, Done=1, total fetches=8.
- Memory inserts 4 wait cycles per fetch -> MemReq and Addr are stable for 5 cycles each; results identical to the zero-wait run.
- Program: ADDI r1,r0,0x40; SLL r2,r1,2; SRL r3,r1,3; ADDI r0,r0,7; MUL r4,r2,r3 -> r2=0x100, r3=0x8, r0=0, r4=0x800.
- Instruction op=0x3F not used; fetch word op=0x12 at addr 2 -> Err=1, Done=0, PC_out=2; a following Start clears Err and restarts at 0.
- With GPP_DIV_EN, DIV r3,r1,r2 where r2=0 -> r3=all ones, Err=1. Without the macro, the same word gives Err=1 and r3 unchanged. Rst asserted mid-fetch -> all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/gpp_core_param.sv
// gpp_core_param: parametrised multi-cycle MIPS-subset core fetching over a req/ack memory port.
// Define GPP_DIV_EN to build the unsigned divider (fn 26); without it fn 26 is an illegal function.
module gpp_core_param #(
  parameter int unsigned DW       = 32,
  parameter int unsigned AW       = 16,
  parameter int unsigned RA_W     = 5,
  parameter int unsigned PROG_LEN = 256
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          Start,
  output logic [AW-1:0] Addr,
  input  logic [31:0]   RData,
  output logic          MemReq,
  input  logic          MemAck,
  output logic          Busy,
  output logic          Done,
  output logic          Err,
  output logic [AW-1:0] PC_out
);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_DONE, S_ERROR} state_t;

  localparam logic [5:0] OP_R    = 6'd0;
  localparam logic [5:0] OP_BEQ  = 6'd4;
  localparam logic [5:0] OP_BNE  = 6'd5;
  localparam logic [5:0] OP_ADDI = 6'd8;
  localparam logic [5:0] OP_HALT = 6'd63;
  localparam logic [5:0] FN_SLL  = 6'd0;
  localparam logic [5:0] FN_SRL  = 6'd2;
  localparam logic [5:0] FN_MUL  = 6'd24;
  localparam logic [5:0] FN_ADD  = 6'd32;
  localparam logic [5:0] FN_SUB  = 6'd34;
  localparam logic [5:0] FN_AND  = 6'd36;
  localparam logic [5:0] FN_OR   = 6'd37;
`ifdef GPP_DIV_EN
  localparam logic [5:0] FN_DIV  = 6'd26;
`endif

  localparam logic [AW:0]   PROG_LIMIT = (AW+1)'(PROG_LEN);
  localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
  localparam logic [AW-1:0] PC_ONE     = AW'(1);

  state_t          state, state_nx;
  logic [AW-1:0]   pc, pc_nx;
  logic [31:0]     ir;
  logic [AW:0]     fetch_cnt;
  logic [DW-1:0]   regs [2**RA_W];
  logic            busy_r, done_r, err_r;

  logic [5:0]      op, fn;
  logic [4:0]      sh;
  logic [15:0]     imm;
  logic [RA_W-1:0] rs, rt, rd;
  logic [DW-1:0]   a, b, simm;
  logic [AW-1:0]   boff;

  logic            wr_en;
  logic [RA_W-1:0] wr_addr;
  logic [DW-1:0]   wr_data;

  assign op   = ir[31:26];
  assign rs   = RA_W'(ir[25:21]);
  assign rt   = RA_W'(ir[20:16]);
  assign rd   = RA_W'(ir[15:11]);
  assign sh   = ir[10:6];
  assign fn   = ir[5:0];
  assign imm  = ir[15:0];
  // r0 is never written, so a plain array read already returns 0 for it
  assign a    = regs[rs];
  assign b    = regs[rt];
  assign simm = DW'($signed(imm));
  assign boff = AW'($signed(imm));

  assign Addr   = pc;
  assign PC_out = pc;
  assign MemReq = (state == S_FETCH) && (fetch_cnt != PROG_LIMIT);
  assign Busy   = busy_r;
  assign Done   = done_r;
  assign Err    = err_r;

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    wr_en    = 1'b0;
    wr_addr  = rd;
    wr_data  = '0;
    case (state)
      S_IDLE:   if (Start) state_nx = S_FETCH;
      S_FETCH: begin
        if (fetch_cnt == PROG_LIMIT) state_nx = S_DONE;
        else if (MemAck)             state_nx = S_DECODE;
      end
      S_DECODE: state_nx = S_EXEC;
      S_EXEC: begin
        state_nx = S_FETCH;
        pc_nx    = pc + PC_ONE;
        case (op)
          OP_R: begin
            wr_en = 1'b1;
            case (fn)
              FN_SLL: wr_data = b << sh;
              FN_SRL: wr_data = b >> sh;
              FN_MUL: wr_data = a * b;
              FN_ADD: wr_data = a + b;
              FN_SUB: wr_data = a - b;
              FN_AND: wr_data = a & b;
              FN_OR:  wr_data = a | b;
`ifdef GPP_DIV_EN
              FN_DIV: begin
                if (b == '0) begin
                  wr_data  = '1;
                  state_nx = S_ERROR;
                  pc_nx    = pc;
                end else begin
                  wr_data = a / b;
                end
              end
`endif
              default: begin
                wr_en    = 1'b0;
                state_nx = S_ERROR;
                pc_nx    = pc;
              end
            endcase
          end
          OP_ADDI: begin
            wr_en   = 1'b1;
            wr_addr = rt;
            wr_data = a + simm;
          end
          OP_BEQ:  if (a == b) pc_nx = pc + PC_ONE + boff;
          OP_BNE:  if (a != b) pc_nx = pc + PC_ONE + boff;
          OP_HALT: begin
            state_nx = S_DONE;
            pc_nx    = pc;
          end
          default: begin
            state_nx = S_ERROR;
            pc_nx    = pc;
          end
        endcase
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= S_IDLE;
      pc        <= '0;
      ir        <= '0;
      fetch_cnt <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      for (int unsigned i = 0; i < 2**RA_W; i++) regs[i] <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (Start) begin
            pc        <= '0;
            fetch_cnt <= '0;
            busy_r    <= 1'b1;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
          end
        end
        S_FETCH: begin
          if (state_nx == S_DECODE) begin
            ir        <= RData;
            fetch_cnt <= fetch_cnt + CNT_ONE;
          end
        end
        S_EXEC: begin
          pc <= pc_nx;
          if (wr_en && (wr_addr != '0)) regs[wr_addr] <= wr_data;
        end
        default: ;
      endcase
      // flags move on the edge into the terminal state so Busy and Done/Err switch together
      if (state_nx == S_DONE) begin
        done_r <= 1'b1;
        busy_r <= 1'b0;
      end
      if (state_nx == S_ERROR) begin
        err_r  <= 1'b1;
        busy_r <= 1'b0;
      end
    end
  end
endmodule
